classifier_feeder: RTL and testbench

CLASSIFIER_FEEDER -- requirements
Module: classifier_feeder

---
 rtl/classifier_feeder_pkg.sv | 18 +
 rtl/feat_store.sv | 48 ++++
 rtl/classifier_feeder.sv | 122 ++++++++++++
 tb/tb_classifier_feeder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/classifier_feeder_pkg.sv
// Shared constants for the classifier feeder and the classifier it drives:
// default sizes, FSM state encoding and the two result codes.
package classifier_feeder_pkg;
   localparam int N_FEAT_DEF   = 30;
   localparam int WAIT_MAX_DEF = 16;
   localparam int ADDR_W       = 5;
   localparam int DATA_W       = 2;
   localparam int WEIGHT_W     = 9;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ISSUE  = 3'd1;
   localparam logic [2:0] ST_STREAM = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [1:0] RES_POS = 2'b01;
   localparam logic [1:0] RES_NEG = 2'b11;
endpackage

// File: rtl/feat_store.sv
// Dual register file (feature data + weight) with one write port and a
// combinational read at the stream index; out-of-range addresses are inert.
module feat_store
   import classifier_feeder_pkg::*;
#(
   parameter int N_FEAT = N_FEAT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [WEIGHT_W-1:0] wr_weight,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_data,
   output logic [WEIGHT_W-1:0] rd_weight
);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(N_FEAT);

   logic [DATA_W-1:0]   data_q   [N_FEAT];
   logic [DATA_W-1:0]   data_d   [N_FEAT];
   logic [WEIGHT_W-1:0] weight_q [N_FEAT];
   logic [WEIGHT_W-1:0] weight_d [N_FEAT];

   always_comb begin
      data_d   = data_q;
      weight_d = weight_q;
      if (wr_en && ({1'b0, wr_addr} < LIMIT)) begin
         data_d[wr_addr]   = wr_data;
         weight_d[wr_addr] = wr_weight;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_FEAT; i++) begin
            data_q[i]   <= '0;
            weight_q[i] <= '0;
         end
      end else begin
         data_q   <= data_d;
         weight_q <= weight_d;
      end
   end

   assign rd_data   = ({1'b0, rd_addr} < LIMIT) ? data_q[rd_addr]   : '0;
   assign rd_weight = ({1'b0, rd_addr} < LIMIT) ? weight_q[rd_addr] : '0;
endmodule

// File: rtl/classifier_feeder.sv
// Streams a stored feature/weight vector to an external classifier after a
// one-cycle enable, then waits (bounded) for its result and reports it.
module classifier_feeder
   import classifier_feeder_pkg::*;
#(
   parameter int N_FEAT   = N_FEAT_DEF,
   parameter int WAIT_MAX = WAIT_MAX_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [WEIGHT_W-1:0] wr_weight,
   input  logic                bias_wr,
   input  logic [WEIGHT_W-1:0] bias_in,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [1:0]          label,
   output logic                timeout,
   output logic                cls_en,
   output logic [DATA_W-1:0]   cls_data,
   output logic [WEIGHT_W-1:0] cls_weight,
   output logic [WEIGHT_W-1:0] cls_bias,
   input  logic [1:0]          cls_result,
   input  logic                cls_ready,
   output logic [2:0]          dbg_state
);
   localparam int WC_W = $clog2(WAIT_MAX + 1);

   logic [2:0]          state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [WC_W-1:0]     wcnt_q, wcnt_d;
   logic [1:0]          label_q, label_d;
   logic                timeout_q, timeout_d;
   logic [WEIGHT_W-1:0] bias_q, bias_d;
   logic [DATA_W-1:0]   rd_data;
   logic [WEIGHT_W-1:0] rd_weight;

   // Busy drops in DONE so writes and the next start are accepted right after.
   assign busy = (state_q == ST_ISSUE) || (state_q == ST_STREAM) || (state_q == ST_WAIT);

   feat_store #(.N_FEAT(N_FEAT)) u_store (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en && !busy),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_weight (wr_weight),
      .rd_addr   (cnt_q),
      .rd_data   (rd_data),
      .rd_weight (rd_weight)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wcnt_d    = wcnt_q;
      label_d   = label_q;
      timeout_d = timeout_q;
      bias_d    = (bias_wr && !busy) ? bias_in : bias_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_ISSUE;
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (cnt_q == ADDR_W'(N_FEAT - 1)) begin
               wcnt_d  = '0;
               state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT: begin
            // A ready on the last allowed cycle still wins over the timeout.
            if (cls_ready) begin
               label_d   = cls_result;
               timeout_d = 1'b0;
               state_d   = ST_DONE;
            end else if (wcnt_q == WC_W'(WAIT_MAX - 1)) begin
               label_d   = 2'b00;
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         wcnt_q    <= '0;
         label_q   <= '0;
         timeout_q <= 1'b0;
         bias_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wcnt_q    <= wcnt_d;
         label_q   <= label_d;
         timeout_q <= timeout_d;
         bias_q    <= bias_d;
      end
   end

   assign done       = (state_q == ST_DONE);
   assign cls_en     = (state_q == ST_ISSUE);
   assign cls_data   = (state_q == ST_STREAM) ? rd_data   : '0;
   assign cls_weight = (state_q == ST_STREAM) ? rd_weight : '0;
   assign cls_bias   = bias_q;
   assign label      = label_q;
   assign timeout    = timeout_q;
   assign dbg_state  = state_q;
endmodule

// File: tb/tb_classifier_feeder.sv
// Self-checking bench for classifier_feeder: directed and randomized runs
// against a vector/weight model and a behavioural classifier stub.
module tb_classifier_feeder;
   import classifier_feeder_pkg::*;

   localparam int N  = N_FEAT_DEF;
   localparam int WM = WAIT_MAX_DEF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [1:0] wr_data = '0;
   logic [8:0] wr_weight = '0;
   logic       bias_wr = 1'b0;
   logic [8:0] bias_in = '0;
   logic       start = 1'b0;
   logic [1:0] cls_result = '0;
   logic       cls_ready = 1'b0;
   logic       busy, done, timeout, cls_en;
   logic [1:0] label, cls_data;
   logic [8:0] cls_weight, cls_bias;
   logic [2:0] dbg_state;

   classifier_feeder dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_weight(wr_weight), .bias_wr(bias_wr), .bias_in(bias_in), .start(start),
      .busy(busy), .done(done), .label(label), .timeout(timeout), .cls_en(cls_en),
      .cls_data(cls_data), .cls_weight(cls_weight), .cls_bias(cls_bias),
      .cls_result(cls_result), .cls_ready(cls_ready), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Reference model of the stores and bias, plus the expected stream queue.
   logic [1:0]  m_data   [N];
   logic [8:0]  m_weight [N];
   logic [8:0]  m_bias = '0;
   logic [10:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_entry(input logic [4:0] a, input logic [1:0] d, input logic [8:0] w);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_weight = w;
      if (int'(a) < N) begin
         m_data[a]   = d;
         m_weight[a] = w;
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic load_bias(input logic [8:0] b);
      @(negedge clk);
      bias_wr = 1'b1; bias_in = b; m_bias = b;
      @(posedge clk); #1;
      bias_wr = 1'b0;
   endtask

   function automatic logic [1:0] classify();
      int s;
      s = int'($signed(m_bias));
      for (int i = 0; i < N; i++) s += int'($signed(m_data[i])) * int'($signed(m_weight[i]));
      return (s >= 0) ? RES_POS : RES_NEG;
   endfunction

   // One classification: stub answers rdy_dly cycles into the wait (never if >= WM).
   task automatic run(input int rdy_dly, input bit inject, input bit wr_same);
      logic [10:0] e;
      logic [1:0]  res;
      int          lat;
      int          n_done;
      lat = -1;
      n_done = 0;
      @(negedge clk);
      start = 1'b1;
      if (wr_same) begin
         wr_en = 1'b1; wr_addr = 5'd0;
         wr_data = 2'($urandom_range(0, 3)); wr_weight = 9'($urandom_range(0, 511));
         m_data[0] = wr_data; m_weight[0] = wr_weight;
      end
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back({m_data[i], m_weight[i]});
      res = classify();
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      check("issue_cls_en", 32'(cls_en), 32'd1);
      check("issue_busy", 32'(busy), 32'd1);
      check("issue_cls_data", 32'(cls_data), 32'd0);
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         check("stream_data", 32'(cls_data), 32'(e[10:9]));
         check("stream_weight", 32'(cls_weight), 32'(e[8:0]));
         if (cls_en !== 1'b0 || done !== 1'b0) check("stream_en_done", {cls_en, done}, 32'd0);
         start = 1'b0; wr_en = 1'b0; bias_wr = 1'b0; cls_ready = 1'b0;
         if (inject && k == 3) begin
            start = 1'b1; wr_en = 1'b1; wr_addr = 5'd3;
            wr_data = ~m_data[3]; wr_weight = ~m_weight[3];
            bias_wr = 1'b1; bias_in = ~m_bias;
            cls_ready = 1'b1; cls_result = ~res;
         end
      end
      for (int w = 0; w < WM + 4; w++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = N + 2 + w;
            n_done++;
            break;
         end
         cls_ready = (w == rdy_dly);
         cls_result = res;
      end
      cls_ready = 1'b0;
      check("latency", 32'(lat), (rdy_dly < WM) ? 32'(N + 3 + rdy_dly) : 32'(N + 2 + WM));
      check("label", 32'(label), (rdy_dly < WM) ? 32'(res) : 32'd0);
      check("timeout", 32'(timeout), (rdy_dly < WM) ? 32'd0 : 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("cls_bias", 32'(cls_bias), 32'(m_bias));
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      check("done_pulses", 32'(n_done), 32'd1);
      check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin m_data[i] = '0; m_weight[i] = '0; end
      #3 rst = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_label", 32'(label), 32'd0);
      check("rst_bias", 32'(cls_bias), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // +1 x +2 everywhere, bias -5: positive result
      for (int i = 0; i < N; i++) load_entry(5'(i), 2'b01, 9'd2);
      load_bias(9'h1FB);
      run(2, 1'b0, 1'b0);

      // Reset while streaming element 10
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (11) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_outs", {busy, done, label, timeout, cls_en, cls_data, cls_weight, cls_bias, dbg_state}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin m_data[i] = '0; m_weight[i] = '0; end
      m_bias = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post_rst_quiet", {done, busy, cls_en}, 32'd0);
      end
      run(2, 1'b0, 1'b0);

      // -1 x +3 everywhere, bias 0: negative result at N+5
      for (int i = 0; i < N; i++) load_entry(5'(i), 2'b11, 9'd3);
      load_bias(9'd0);
      run(2, 1'b0, 1'b0);

      // Silent classifier
      run(WM + 10, 1'b0, 1'b0);

      // Out-of-range addresses leave the stores untouched
      load_entry(5'd31, 2'b01, 9'h055);
      load_entry(5'd30, 2'b10, 9'h0AA);
      run(1, 1'b0, 1'b0);

      // Random vector; mid-stream start/write/bias/ready are all ignored
      for (int i = 0; i < N; i++) load_entry(5'(i), 2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
      load_bias(9'($urandom_range(0, 511)));
      run(3, 1'b1, 1'b0);

      // Write and start in the same cycle
      run(0, 1'b0, 1'b1);

      // Randomized runs, including ready on the last allowed wait cycle
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) load_entry(5'(i), 2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
         load_bias(9'($urandom_range(0, 511)));
         run((r == 3) ? WM - 1 : int'($urandom_range(0, WM - 1)), 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
